// File: rtl/mips_mem_arb_if.sv
// Request/response bundle between the MIPS fetch/data ports and mips_mem_arb.
// i_err/d_err exist only when MIPS_MEM_ERR_EN is defined.
interface mips_mem_arb_if #(
   parameter int WIDTH     = 8,
   parameter int ADDR_BITS = 8
);
   logic                 i_req;
   logic [ADDR_BITS-1:0] i_adr;
   logic [WIDTH-1:0]     i_rdata;
   logic                 i_ready;
   logic                 d_req;
   logic                 d_we;
   logic [ADDR_BITS-1:0] d_adr;
   logic [WIDTH-1:0]     d_wdata;
   logic [WIDTH-1:0]     d_rdata;
   logic                 d_ready;
   logic                 busy;
`ifdef MIPS_MEM_ERR_EN
   logic                 i_err;
   logic                 d_err;
`endif

   modport slave (
      input  i_req, i_adr, d_req, d_we, d_adr, d_wdata,
      output i_rdata, i_ready, d_rdata, d_ready, busy
`ifdef MIPS_MEM_ERR_EN
      , output i_err, d_err
`endif
   );

   modport master (
      output i_req, i_adr, d_req, d_we, d_adr, d_wdata,
      input  i_rdata, i_ready, d_rdata, d_ready, busy
`ifdef MIPS_MEM_ERR_EN
      , input i_err, d_err
`endif
   );
endinterface

// File: rtl/mips_mem_arb.sv
// Shared on-chip RAM for the MIPS I/D channels: round-robin arbiter with WAIT_STATES latency.
// Define MIPS_MEM_ERR_EN to add out-of-range error pulses (i_err/d_err).
module mips_mem_arb #(
   parameter int WIDTH       = 8,
   parameter int ADDR_BITS   = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 1
) (
   input  logic           clk,
   input  logic           reset,
   mips_mem_arb_if.slave  bus
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
   typedef enum logic {CH_I = 1'b0, CH_D = 1'b1} chan_t;

   typedef struct packed {
      chan_t                ch;
      logic                 we;
      logic [ADDR_BITS-1:0] adr;
      logic [WIDTH-1:0]     wdata;
   } req_t;

   state_t           state_q, state_d;
   req_t             req_q, req_d;
   logic [3:0]       cnt_q, cnt_d;
   chan_t            last_q, last_d;
   logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
   logic [WIDTH-1:0] d_rdata_q, d_rdata_d;
   logic             i_ready_q, i_ready_d;
   logic             d_ready_q, d_ready_d;
`ifdef MIPS_MEM_ERR_EN
   logic             i_err_q, i_err_d;
   logic             d_err_q, d_err_d;
`endif

   logic [WIDTH-1:0] ram [DEPTH];
   logic             in_range;
   logic             fire;
   logic             ram_we;
   logic [WIDTH-1:0] rd_word;
   chan_t            gnt;

   // Access happens on the edge that leaves ACCESS with the counter exhausted.
   always_comb begin
      in_range = ({1'b0, req_q.adr} < (ADDR_BITS+1)'(DEPTH));
      fire     = (state_q == S_ACCESS) && (cnt_q == 4'd0);
      ram_we   = fire && (req_q.ch == CH_D) && req_q.we && in_range;
      rd_word  = in_range ? ram[req_q.adr[IDX_W-1:0]] : '0;
      gnt      = (bus.i_req && (!bus.d_req || last_q == CH_D)) ? CH_I : CH_D;
   end

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ready_d = 1'b0;
      d_ready_d = 1'b0;
`ifdef MIPS_MEM_ERR_EN
      i_err_d   = 1'b0;
      d_err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.i_req || bus.d_req) begin
               req_d.ch    = gnt;
               req_d.we    = (gnt == CH_D) && bus.d_we;
               req_d.adr   = (gnt == CH_D) ? bus.d_adr : bus.i_adr;
               req_d.wdata = bus.d_wdata;
               cnt_d       = 4'(WAIT_STATES);
               state_d     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               if (req_q.ch == CH_I) begin
                  i_rdata_d = rd_word;
                  i_ready_d = 1'b1;
`ifdef MIPS_MEM_ERR_EN
                  i_err_d   = !in_range;
`endif
               end else begin
                  // Writes leave d_rdata untouched.
                  if (!req_q.we) d_rdata_d = rd_word;
                  d_ready_d = 1'b1;
`ifdef MIPS_MEM_ERR_EN
                  d_err_d   = !in_range;
`endif
               end
               last_d  = req_q.ch;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         req_q     <= '0;
         cnt_q     <= '0;
         last_q    <= CH_D;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
`ifdef MIPS_MEM_ERR_EN
         i_err_q   <= 1'b0;
         d_err_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
         i_ready_q <= i_ready_d;
         d_ready_q <= d_ready_d;
`ifdef MIPS_MEM_ERR_EN
         i_err_q   <= i_err_d;
         d_err_q   <= d_err_d;
`endif
      end
   end

   // RAM is not reset; reset forces IDLE so an aborted write never reaches it.
   always_ff @(posedge clk) begin
      if (ram_we) ram[req_q.adr[IDX_W-1:0]] <= req_q.wdata;
   end

   assign bus.i_rdata = i_rdata_q;
   assign bus.i_ready = i_ready_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.d_ready = d_ready_q;
   assign bus.busy    = (state_q != S_IDLE);
`ifdef MIPS_MEM_ERR_EN
   assign bus.i_err   = i_err_q;
   assign bus.d_err   = d_err_q;
`endif
endmodule

// File: tb/tb_mips_mem_arb.sv
// Bench for mips_mem_arb: directed literal checks, then random I/D traffic against a
// transaction-timeline model compared every cycle on the falling edge.
module tb_mips_mem_arb;
   localparam int WS    = 1;
   localparam int DEPTH = 200;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   rnd_en = 1'b0;

   always #5 clk = ~clk;

   mips_mem_arb_if #(.WIDTH(8), .ADDR_BITS(8)) bus ();
   mips_mem_arb #(.WIDTH(8), .ADDR_BITS(8), .DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
      .clk(clk), .reset(reset), .bus(bus));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: a granted transaction occupies WS+2 cycles; its effect lands entering the last one,
   // which is the ready cycle.
   int         m_left;
   bit         m_ch, m_we, m_last;
   logic [7:0] m_adr, m_wd, m_ir, m_dr;
   logic [7:0] m_mem [256];

   always @(negedge clk) begin
      if (reset) begin
         m_left = 0; m_ir = 8'h00; m_dr = 8'h00; m_last = 1'b1;
      end
      chk("busy",    bus.busy,    m_left > 0);
      chk("i_ready", bus.i_ready, m_left == 1 && !m_ch);
      chk("d_ready", bus.d_ready, m_left == 1 && m_ch);
      chk("i_rdata", bus.i_rdata, m_ir);
      chk("d_rdata", bus.d_rdata, m_dr);
`ifdef MIPS_MEM_ERR_EN
      chk("i_err", bus.i_err, m_left == 1 && !m_ch && m_adr >= DEPTH);
      chk("d_err", bus.d_err, m_left == 1 && m_ch && m_adr >= DEPTH);
`endif
      if (!reset) begin
         if (m_left == 0) begin
            if (bus.i_req || bus.d_req) begin
               m_ch   = (bus.i_req && bus.d_req) ? !m_last : bus.d_req;
               m_adr  = m_ch ? bus.d_adr : bus.i_adr;
               m_we   = m_ch && bus.d_we;
               m_wd   = bus.d_wdata;
               m_left = WS + 2;
            end
         end else begin
            if (m_left == 2) begin
               if (!m_ch) m_ir = (m_adr < DEPTH) ? m_mem[m_adr] : 8'h00;
               else if (m_we) begin
                  if (m_adr < DEPTH) m_mem[m_adr] = m_wd;
               end else m_dr = (m_adr < DEPTH) ? m_mem[m_adr] : 8'h00;
               m_last = m_ch;
            end
            m_left--;
         end
      end
   end

   task automatic drive(input bit ch, input bit we, input logic [7:0] a, input logic [7:0] wd);
      if (ch) begin
         bus.d_req = 1'b1; bus.d_we = we; bus.d_adr = a; bus.d_wdata = wd;
      end else begin
         bus.i_req = 1'b1; bus.i_adr = a;
      end
   endtask

   task automatic wait_rdy(input bit ch, output int lat, output bit er);
      bit seen;
      seen = 1'b0; lat = 0; er = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk);
         lat++;
         if ((ch ? bus.d_ready : bus.i_ready) === 1'b1) begin
            seen = 1'b1;
`ifdef MIPS_MEM_ERR_EN
            er = ch ? bus.d_err : bus.i_err;
`endif
         end
      end
      if (!seen) begin
         n_chk++; n_fail++;
         $display("FAIL ready_timeout ch=%0d actual=none required=pulse", ch);
         lat = -1;
      end
   endtask

   task automatic acc(input bit ch, input bit we, input logic [7:0] a, input logic [7:0] wd,
                      output int lat, output bit er);
      drive(ch, we, a, wd);
      wait_rdy(ch, lat, er);
      @(posedge clk); #1;
      if (ch) bus.d_req = 1'b0; else bus.i_req = 1'b0;
   endtask

   task automatic pair(output bit first_d);
      bit found;
      int lat;
      bit er;
      found = 1'b0; first_d = 1'b0;
      bus.i_req = 1'b1; bus.i_adr = 8'h10;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 8'h05;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (bus.i_ready || bus.d_ready) begin
            found = 1'b1; first_d = bus.d_ready;
         end
      end
      if (!found) begin
         n_chk++; n_fail++;
         $display("FAIL pair_timeout actual=none required=ready");
      end
      @(posedge clk); #1;
      if (first_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
      wait_rdy(!first_d, lat, er);
      @(posedge clk); #1;
      bus.i_req = 1'b0; bus.d_req = 1'b0;
   endtask

   function automatic logic [7:0] rnd_adr();
      return 8'($urandom_range(0, 255));
   endfunction

   initial begin : drv_i
      forever begin
         @(posedge clk); #1;
         if (rnd_en) begin
            if (bus.i_req) begin
               if (bus.i_ready) begin
                  if ($urandom_range(1) == 1) bus.i_req = 1'b0; else bus.i_adr = rnd_adr();
               end else if ($urandom_range(3) == 0) bus.i_adr = rnd_adr();
            end else if ($urandom_range(2) == 0) begin
               bus.i_req = 1'b1; bus.i_adr = rnd_adr();
            end
         end
      end
   end

   initial begin : drv_d
      forever begin
         @(posedge clk); #1;
         if (rnd_en) begin
            if (bus.d_req) begin
               if (bus.d_ready) begin
                  if ($urandom_range(1) == 1) bus.d_req = 1'b0;
                  else begin
                     bus.d_adr = rnd_adr(); bus.d_we = 1'($urandom_range(1));
                     bus.d_wdata = 8'($urandom_range(255));
                  end
               end else if ($urandom_range(3) == 0) begin
                  bus.d_adr = rnd_adr(); bus.d_wdata = 8'($urandom_range(255));
                  bus.d_we = 1'($urandom_range(1));
               end
            end else if ($urandom_range(2) == 0) begin
               bus.d_req = 1'b1; bus.d_adr = rnd_adr(); bus.d_we = 1'($urandom_range(1));
               bus.d_wdata = 8'($urandom_range(255));
            end
         end
      end
   end

   initial begin : main
      int lat;
      bit er, er2, first_d;
      int rcnt;
      bus.i_req = 1'b0; bus.i_adr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.d_adr = '0; bus.d_wdata = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", {bus.i_ready, bus.d_ready}, 0);
      chk("rst_i_rdata", bus.i_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);

      // Write/read-back with latency pinned.
      acc(1, 1, 8'h10, 8'hA5, lat, er);
      chk("wr_latency", lat, WS + 3);
      acc(0, 0, 8'h10, 8'h00, lat, er);
      chk("rd_latency", lat, WS + 3);
      chk("rd_after_wr", bus.i_rdata, 8'hA5);

      for (int a = 0; a < DEPTH; a++) if (a != 8'h10) acc(1, 1, 8'(a), 8'(a) ^ 8'h5A, lat, er);

      // Arbitration: I wins the first conflict, alternation afterwards.
      pair(first_d);
      chk("pair1_first_is_i", first_d, 0);
      chk("pair1_d_rdata", bus.d_rdata, 8'h5F);
      acc(0, 0, 8'h10, 8'h00, lat, er);
      pair(first_d);
      chk("pair2_first_is_d", first_d, 1);

      // Last valid word and out-of-range addresses.
      acc(1, 1, 8'hC7, 8'hE1, lat, er);
      acc(1, 0, 8'hC7, 8'h00, lat, er);
      chk("last_word", bus.d_rdata, 8'hE1);
`ifdef MIPS_MEM_ERR_EN
      chk("err_in_range", er, 0);
`endif
      acc(1, 1, 8'hF0, 8'h77, lat, er);
      acc(1, 0, 8'hF0, 8'h00, lat, er2);
      chk("oor_latency", lat, WS + 3);
      chk("oor_read_zero", bus.d_rdata, 8'h00);
`ifdef MIPS_MEM_ERR_EN
      chk("oor_err_wr", er, 1);
      chk("oor_err_rd", er2, 1);
`endif

      // Reset during ACCESS aborts a write.
      drive(1, 1, 8'h05, 8'h3C);
      @(posedge clk); #1;
      reset = 1'b1; bus.d_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      rcnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.d_ready || bus.i_ready) rcnt++;
      end
      chk("rst_no_ready", rcnt, 0);
      @(posedge clk); #1;
      acc(1, 0, 8'h05, 8'h00, lat, er);
      chk("rst_no_write", bus.d_rdata, 8'h5F);

      // Inputs changed after grant must not affect the committed write.
      drive(1, 1, 8'h20, 8'hC3);
      @(posedge clk); #1;
      bus.d_adr = 8'h21; bus.d_wdata = 8'h99; bus.d_we = 1'b0;
      wait_rdy(1, lat, er);
      @(posedge clk); #1;
      bus.d_req = 1'b0;
      acc(1, 0, 8'h20, 8'h00, lat, er);
      chk("latch_adr_data", bus.d_rdata, 8'hC3);
      acc(0, 0, 8'h21, 8'h00, lat, er);
      chk("latch_other_adr", bus.i_rdata, 8'h7B);

      rnd_en = 1'b1;
      repeat (3000) @(posedge clk);
      #1;
      rnd_en = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
      rcnt = 0;
      while (bus.busy && rcnt < 20) begin
         @(posedge clk); #1;
         rcnt++;
      end
      chk("drain_idle", bus.busy, 0);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
